phase_accumulator: RTL and testbench

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

---
 rtl/phase_accumulator_if.sv | 39 +++
 rtl/phase_accumulator.sv | 100 ++++++++++
 tb/tb_phase_accumulator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_accumulator_if.sv
// Stream-side bundle of the phase accumulator: increment input, phase sample
// output and the wrap qualifiers that travel with each sample.
interface phase_accumulator_if #(
    parameter int PINC_WIDTH      = 32,
    parameter int PHASE_OUT_WIDTH = 16
);
    logic                       S_AXIS_tvalid;
    logic [PINC_WIDTH-1:0]      S_AXIS_tdata;
    logic                       S_AXIS_tready;
    logic                       M_AXIS_tready;
    logic                       M_AXIS_tvalid;
    logic [PHASE_OUT_WIDTH-1:0] M_AXIS_tdata;
    logic                       wrap;
    logic [15:0]                wrap_count;

    // Driver side: supplies increments and consumes phase samples.
    modport master (
        output S_AXIS_tvalid,
        output S_AXIS_tdata,
        output M_AXIS_tready,
        input  S_AXIS_tready,
        input  M_AXIS_tvalid,
        input  M_AXIS_tdata,
        input  wrap,
        input  wrap_count
    );

    // Accumulator side.
    modport slave (
        input  S_AXIS_tvalid,
        input  S_AXIS_tdata,
        input  M_AXIS_tready,
        output S_AXIS_tready,
        output M_AXIS_tvalid,
        output M_AXIS_tdata,
        output wrap,
        output wrap_count
    );
endinterface

// File: rtl/phase_accumulator.sv
// NCO phase accumulator: one registered phase sample per advance (1-cycle latency),
// increment applies from the advance after capture; a held sample freezes all state.
module phase_accumulator #(
    parameter int PINC_WIDTH      = 32,
    parameter int ACC_WIDTH       = 32,
    parameter int PHASE_OUT_WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic                 sync_on_switch,
    input  logic                 switch_enable,
    input  logic [ACC_WIDTH-1:0] phase_offset,
    phase_accumulator_if.slave   bus
);
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [ACC_WIDTH-1:0]       pinc_q, pinc_d;
    logic                       sw_q;
    logic                       pend_q, pend_d;
    logic                       tvalid_q, tvalid_d;
    logic [PHASE_OUT_WIDTH-1:0] tdata_q, tdata_d;
    logic                       wrap_q, wrap_d;
    logic [15:0]                wcnt_q, wcnt_d;

    logic                       advance;
    logic                       handshake;
    logic                       restart;
    logic                       restart_now;
    logic [ACC_WIDTH-1:0]       acc_base;
    logic [ACC_WIDTH-1:0]       phase_sum;
    logic [ACC_WIDTH:0]         step_sum;

    always_comb begin
        restart     = sync_on_switch & switch_enable & ~sw_q;
        advance     = enable & (~tvalid_q | bus.M_AXIS_tready);
        handshake   = tvalid_q & bus.M_AXIS_tready;
        // A restart seen in the same cycle as an advance applies immediately.
        restart_now = restart | pend_q;
        acc_base    = restart_now ? '0 : acc_q;
        phase_sum   = acc_base + phase_offset;
        step_sum    = {1'b0, acc_base} + {1'b0, pinc_q};
    end

    always_comb begin
        acc_d    = acc_q;
        pinc_d   = pinc_q;
        pend_d   = pend_q | restart;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        wrap_d   = wrap_q;
        wcnt_d   = wcnt_q;

        if (bus.S_AXIS_tvalid) begin
            pinc_d = ACC_WIDTH'(bus.S_AXIS_tdata);
        end

        // Counts the sample leaving this cycle, before it is replaced.
        if (handshake && wrap_q && (wcnt_q != 16'hFFFF)) begin
            wcnt_d = wcnt_q + 16'd1;
        end

        if (advance) begin
            tvalid_d = 1'b1;
            tdata_d  = PHASE_OUT_WIDTH'(phase_sum >> (ACC_WIDTH - PHASE_OUT_WIDTH));
            wrap_d   = step_sum[ACC_WIDTH];
            acc_d    = step_sum[ACC_WIDTH-1:0];
            pend_d   = 1'b0;
        end else if (handshake) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc_q    <= '0;
            pinc_q   <= '0;
            sw_q     <= 1'b0;
            pend_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            wrap_q   <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            pinc_q   <= pinc_d;
            sw_q     <= switch_enable;
            pend_q   <= pend_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            wrap_q   <= wrap_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign bus.S_AXIS_tready = ~areset;
    assign bus.M_AXIS_tvalid = tvalid_q;
    assign bus.M_AXIS_tdata  = tdata_q;
    assign bus.wrap          = wrap_q;
    assign bus.wrap_count    = wcnt_q;
endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator with hand-computed phase sequences.
module tb_phase_accumulator;
    logic        aclk;
    logic        areset;
    logic        enable;
    logic        sync_on_switch;
    logic        switch_enable;
    logic [31:0] phase_offset;

    int checks;
    int errors;

    phase_accumulator_if #(.PINC_WIDTH(32), .PHASE_OUT_WIDTH(16)) bus ();

    phase_accumulator #(
        .PINC_WIDTH(32),
        .ACC_WIDTH(32),
        .PHASE_OUT_WIDTH(16)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .enable(enable),
        .sync_on_switch(sync_on_switch),
        .switch_enable(switch_enable),
        .phase_offset(phase_offset),
        .bus(bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic samp(input string tag, input logic [15:0] d, input logic w);
        chk({tag, " vld"}, 32'(bus.M_AXIS_tvalid), 32'd1);
        chk({tag, " dat"}, 32'(bus.M_AXIS_tdata), 32'(d));
        chk({tag, " wrap"}, 32'(bus.wrap), 32'(w));
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        #2;
        areset = 1'b0;
    endtask

    task automatic load_pinc(input logic [31:0] p);
        bus.S_AXIS_tvalid = 1'b1;
        bus.S_AXIS_tdata  = p;
        tick();
        bus.S_AXIS_tvalid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        areset = 1'b1;
        enable = 1'b0;
        sync_on_switch = 1'b0;
        switch_enable = 1'b0;
        phase_offset = 32'h0;
        bus.S_AXIS_tvalid = 1'b0;
        bus.S_AXIS_tdata  = 32'h0;
        bus.M_AXIS_tready = 1'b1;

        repeat (3) tick();
        chk("rst tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        chk("rst tdata", 32'(bus.M_AXIS_tdata), 32'd0);
        chk("rst wrap", 32'(bus.wrap), 32'd0);
        chk("rst wcnt", 32'(bus.wrap_count), 32'd0);
        chk("rst s_tready", 32'(bus.S_AXIS_tready), 32'd0);
        areset = 1'b0;
        #1;
        chk("run s_tready", 32'(bus.S_AXIS_tready), 32'd1);

        // Basic quarter-turn stream, offset 0.
        load_pinc(32'h4000_0000);
        enable = 1'b1;
        tick(); samp("s1 0", 16'h0000, 1'b0);
        tick(); samp("s1 1", 16'h4000, 1'b0);
        tick(); samp("s1 2", 16'h8000, 1'b0);
        tick(); samp("s1 3", 16'hC000, 1'b1);
        tick(); samp("s1 4", 16'h0000, 1'b0);
        chk("s1 wcnt", 32'(bus.wrap_count), 32'd1);
        enable = 1'b0;
        tick();
        chk("s1 stop tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        chk("s1 stop wcnt", 32'(bus.wrap_count), 32'd1);
        enable = 1'b1;
        tick(); samp("s1 resume", 16'h4000, 1'b0);

        // Half-turn offset, then backpressure on the same stream.
        pulse_reset();
        enable = 1'b0;
        phase_offset = 32'h8000_0000;
        load_pinc(32'h4000_0000);
        enable = 1'b1;
        tick(); samp("s2 0", 16'h8000, 1'b0);
        tick(); samp("s2 1", 16'hC000, 1'b0);
        tick(); samp("s2 2", 16'h0000, 1'b0);
        tick(); samp("s2 3", 16'h4000, 1'b1);
        tick(); samp("s3 0", 16'h8000, 1'b0);
        chk("s3 wcnt", 32'(bus.wrap_count), 32'd1);
        bus.M_AXIS_tready = 1'b0;
        tick(); samp("s3 hold a", 16'h8000, 1'b0);
        tick(); samp("s3 hold b", 16'h8000, 1'b0);
        tick(); samp("s3 hold c", 16'h8000, 1'b0);
        chk("s3 hold wcnt", 32'(bus.wrap_count), 32'd1);
        bus.M_AXIS_tready = 1'b1;
        tick(); samp("s3 1", 16'hC000, 1'b0);
        tick(); samp("s3 2", 16'h0000, 1'b0);

        // Phase restart on a switch_enable rising edge.
        pulse_reset();
        enable = 1'b0;
        phase_offset = 32'h0;
        load_pinc(32'h4000_0000);
        enable = 1'b1;
        tick(); samp("s4 0", 16'h0000, 1'b0);
        tick(); samp("s4 1", 16'h4000, 1'b0);
        tick(); samp("s4 2", 16'h8000, 1'b0);
        sync_on_switch = 1'b1;
        switch_enable  = 1'b1;
        tick(); samp("s4 restart", 16'h0000, 1'b0);
        tick(); samp("s4 after", 16'h4000, 1'b0);
        switch_enable = 1'b0;
        tick(); samp("s4 3", 16'h8000, 1'b0);
        bus.M_AXIS_tready = 1'b0;
        switch_enable = 1'b1;
        tick(); samp("s4 held", 16'h8000, 1'b0);
        bus.M_AXIS_tready = 1'b1;
        tick(); samp("s4 pend restart", 16'h0000, 1'b0);
        tick(); samp("s4 pend after", 16'h4000, 1'b0);
        sync_on_switch = 1'b0;
        switch_enable = 1'b0;
        tick(); samp("s4 nosync 0", 16'h8000, 1'b0);
        switch_enable = 1'b1;
        tick(); samp("s4 nosync 1", 16'hC000, 1'b1);
        tick(); samp("s4 nosync 2", 16'h0000, 1'b0);
        switch_enable = 1'b0;

        // Increment change mid-stream.
        pulse_reset();
        enable = 1'b0;
        load_pinc(32'h4000_0000);
        enable = 1'b1;
        tick(); samp("s5 0", 16'h0000, 1'b0);
        tick(); samp("s5 1", 16'h4000, 1'b0);
        bus.S_AXIS_tvalid = 1'b1;
        bus.S_AXIS_tdata  = 32'h1000_0000;
        tick(); samp("s5 2", 16'h8000, 1'b0);
        bus.S_AXIS_tvalid = 1'b0;
        tick(); samp("s5 3", 16'hC000, 1'b0);
        tick(); samp("s5 4", 16'hD000, 1'b0);
        tick(); samp("s5 5", 16'hE000, 1'b0);
        tick(); samp("s5 6", 16'hF000, 1'b1);
        tick(); samp("s5 7", 16'h0000, 1'b0);
        chk("s5 wcnt", 32'(bus.wrap_count), 32'd1);

        // Reset asserted while a sample is held.
        bus.M_AXIS_tready = 1'b0;
        tick(); samp("s6 held", 16'h0000, 1'b0);
        areset = 1'b1;
        #1;
        chk("s6 rst tvalid", 32'(bus.M_AXIS_tvalid), 32'd0);
        chk("s6 rst tdata", 32'(bus.M_AXIS_tdata), 32'd0);
        chk("s6 rst wcnt", 32'(bus.wrap_count), 32'd0);
        chk("s6 rst s_tready", 32'(bus.S_AXIS_tready), 32'd0);
        areset = 1'b0;
        bus.M_AXIS_tready = 1'b1;
        tick(); samp("s6 first", 16'h0000, 1'b0);
        phase_offset = 32'h1234_5678;
        tick(); samp("s6 zero pinc a", 16'h1234, 1'b0);
        tick(); samp("s6 zero pinc b", 16'h1234, 1'b0);

        // wrap_count saturation: every sample after the first wraps.
        pulse_reset();
        enable = 1'b0;
        phase_offset = 32'h0;
        load_pinc(32'hFFFF_FFFF);
        enable = 1'b1;
        tick(); samp("s7 0", 16'h0000, 1'b0);
        tick(); samp("s7 1", 16'hFFFF, 1'b1);
        repeat (66000) tick();
        chk("s7 wcnt sat", 32'(bus.wrap_count), 32'h0000_FFFF);
        tick();
        chk("s7 wcnt stay", 32'(bus.wrap_count), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
